// File: rtl/msgdma_stream_arbiter_pkg.sv
// Shared types and helpers for the mSGDMA stream arbiter slice.
package msgdma_pkg;

   localparam int unsigned MSGDMA_N = 32;

   typedef enum logic {
      IDLE,
      XFER
   } arb_state_t;

   // Beat counter must be able to represent 0..PKT_LEN.
   function automatic int unsigned cnt_width(input int unsigned pkt_len);
      return $clog2(pkt_len + 1);
   endfunction

endpackage

// File: rtl/msgdma_stream_arbiter_if.sv
// Requester-side and mSGDMA sink-side signals of the stream arbiter.
interface msgdma_stream_arbiter_if
   import msgdma_pkg::*;
#(
   parameter int unsigned N    = MSGDMA_N,
   parameter int unsigned NREQ = 2,
   parameter int unsigned CW   = 3
);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*N-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [N-1:0]      src_data;
   logic              src_valid;
   logic              src_ready;
   logic              src_sop;
   logic              src_eop;
   logic [CW-1:0]     src_channel;
   logic [NREQ-1:0]   grant;
   logic              busy;

   modport master (
      output req_valid, req_data, src_ready,
      input  req_ready, src_data, src_valid, src_sop, src_eop, src_channel, grant, busy
   );

   modport slave (
      input  req_valid, req_data, src_ready,
      output req_ready, src_data, src_valid, src_sop, src_eop, src_channel, grant, busy
   );

endinterface

// File: rtl/msgdma_stream_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request found searching from last+1, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned CW   = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [CW-1:0]   last,
   output logic [NREQ-1:0] gnt,
   output logic [CW-1:0]   idx
);

   logic            found;
   int unsigned     cand;
   logic [NREQ-1:0] rs;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      rs    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = (32'(last) + k) % NREQ;
         rs   = req >> cand;
         if (!found && rs[0]) begin
            found = 1'b1;
            gnt   = NREQ'(1) << cand;
            idx   = CW'(cand);
         end
      end
   end

endmodule

// File: rtl/msgdma_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing one mSGDMA stream sink among NREQ producers.
module msgdma_stream_arbiter
   import msgdma_pkg::*;
#(
   parameter int unsigned N       = MSGDMA_N,
   parameter int unsigned NREQ    = 2,
   parameter int unsigned PKT_LEN = 4,
   parameter int unsigned CW      = 3
) (
   input logic                    clk,
   input logic                    reset,
   msgdma_stream_arbiter_if.slave bus
);

   localparam int unsigned CNTW = cnt_width(PKT_LEN);

   arb_state_t      state;
   logic [NREQ-1:0] grant_r;
   logic [NREQ-1:0] arb_gnt;
   logic [NREQ-1:0] req_ready_c;
   logic [CW-1:0]   chan_r;
   logic [CW-1:0]   last_r;
   logic [CW-1:0]   arb_idx;
   logic [CNTW-1:0] cnt;
   logic [N-1:0]    src_data_r;
   logic [N-1:0]    word_sel;
   logic [CW-1:0]   src_channel_r;
   logic            src_valid_r;
   logic            src_sop_r;
   logic            src_eop_r;
   logic            ofree;
   logic            accept;
   logic            last_beat;

   rr_arbiter #(
      .NREQ (NREQ),
      .CW   (CW)
   ) u_rr (
      .req  (bus.req_valid),
      .last (last_r),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   // Ready depends only on registered state and src_ready, never on req_valid.
   always_comb begin
      ofree       = !src_valid_r || bus.src_ready;
      req_ready_c = (state == XFER) ? (grant_r & {NREQ{ofree}}) : '0;
      accept      = |(bus.req_valid & req_ready_c);
      last_beat   = (cnt == CNTW'(PKT_LEN - 1));
      word_sel    = N'(bus.req_data >> (32'(chan_r) * N));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         grant_r       <= '0;
         chan_r        <= '0;
         last_r        <= CW'(NREQ - 1);
         cnt           <= '0;
         src_data_r    <= '0;
         src_channel_r <= '0;
         src_valid_r   <= 1'b0;
         src_sop_r     <= 1'b0;
         src_eop_r     <= 1'b0;
      end else begin
         if (src_valid_r && bus.src_ready && !accept)
            src_valid_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  grant_r <= arb_gnt;
                  chan_r  <= arb_idx;
                  cnt     <= '0;
                  state   <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  src_data_r    <= word_sel;
                  src_channel_r <= chan_r;
                  src_valid_r   <= 1'b1;
                  src_sop_r     <= (cnt == '0);
                  src_eop_r     <= last_beat;
                  if (last_beat) begin
                     last_r  <= chan_r;
                     grant_r <= '0;
                     cnt     <= '0;
                     state   <= IDLE;
                  end else begin
                     cnt <= cnt + CNTW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = req_ready_c;
   assign bus.src_data    = src_data_r;
   assign bus.src_valid   = src_valid_r;
   assign bus.src_sop     = src_sop_r;
   assign bus.src_eop     = src_eop_r;
   assign bus.src_channel = src_channel_r;
   assign bus.grant       = grant_r;
   assign bus.busy        = (state == XFER) || src_valid_r;

endmodule

// File: tb/tb_msgdma_stream_arbiter.sv
// Bench: vector table plus corner sequences and a randomized run against a transaction-level model.
module tb_msgdma_stream_arbiter;

   localparam int unsigned PKT_A = 4;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   n_chk;
   int   n_err;

   msgdma_stream_arbiter_if #(.N(32), .NREQ(2), .CW(3)) a_if ();
   msgdma_stream_arbiter_if #(.N(32), .NREQ(3), .CW(3)) b_if ();

   msgdma_stream_arbiter #(.N(32), .NREQ(2), .PKT_LEN(PKT_A), .CW(3)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (a_if.slave)
   );

   msgdma_stream_arbiter #(.N(32), .NREQ(3), .PKT_LEN(1), .CW(3)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (b_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic [1:0]  v;
      logic        r;
      logic [1:0]  rdy;
      logic        sv;
      logic [31:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  ch;
      logic [1:0]  g;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] base_a[2];
   logic [31:0] base_b[3];
   int unsigned pseq_a[2];
   int unsigned pseq_b[3];
   logic [1:0]  hs_a;
   logic [2:0]  hs_b;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic [1:0] v, input logic r,
                               input logic [1:0] rdy, input logic sv, input logic [31:0] d,
                               input logic sop, input logic eop, input logic [2:0] ch,
                               input logic [1:0] g);
      vec_t x;
      x = '{rst: rst, v: v, r: r, rdy: rdy, sv: sv, d: d, sop: sop, eop: eop, ch: ch, g: g};
      return x;
   endfunction

   task automatic set_a(input logic [1:0] v, input logic r);
      a_if.req_valid = v;
      a_if.src_ready = r;
      for (int i = 0; i < 2; i++) a_if.req_data[i*32 +: 32] = base_a[i] + pseq_a[i];
      #1;
      hs_a = v & a_if.req_ready;
   endtask

   task automatic tick_a();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (hs_a[i]) pseq_a[i]++;
   endtask

   task automatic set_b(input logic [2:0] v, input logic r);
      b_if.req_valid = v;
      b_if.src_ready = r;
      for (int i = 0; i < 3; i++) b_if.req_data[i*32 +: 32] = base_b[i] + pseq_b[i];
      #1;
      hs_b = v & b_if.req_ready;
   endtask

   task automatic tick_b();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (hs_b[i]) pseq_b[i]++;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      set_a(2'b00, 1'b1);
      tick_a();
      rst_a = 1'b0;
      pseq_a = '{0, 0};
   endtask

   // Transaction-level reference for the randomized run
   logic        m_xfer, m_ov, m_sop, m_eop, m_acc, m_was, m_free, m_pick;
   logic [31:0] m_od;
   int unsigned m_owner, m_last, m_beat, m_ch, m_c;
   int unsigned m_seq[2];

   initial begin
      clk = 1'b0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      n_chk = 0;
      n_err = 0;
      base_a = '{32'hA0, 32'h20};
      base_b = '{32'h100, 32'h200, 32'h300};
      pseq_a = '{0, 0};
      pseq_b = '{0, 0, 0};
      hs_a = '0;
      hs_b = '0;
      set_b(3'b000, 1'b1);

      //            rst  v     r  rdy   sv  data    sop  eop  ch    g
      tbl.push_back(mk(1, 2'b00, 1, 2'b00, 0, 32'h00, 0, 0, 3'd0, 2'b00));
      tbl.push_back(mk(0, 2'b01, 1, 2'b00, 0, 32'h00, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 1, 2'b01, 1, 32'hA0, 1, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 1, 2'b01, 1, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 1, 2'b01, 1, 32'hA2, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 1, 2'b01, 1, 32'hA3, 0, 1, 3'd0, 2'b00));
      tbl.push_back(mk(0, 2'b00, 1, 2'b00, 0, 32'hA3, 0, 1, 3'd0, 2'b00));
      // two requesters alternate with one bubble between packets
      tbl.push_back(mk(1, 2'b00, 1, 2'b00, 0, 32'h00, 0, 0, 3'd0, 2'b00));
      tbl.push_back(mk(0, 2'b11, 1, 2'b00, 0, 32'h00, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA0, 1, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA2, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA3, 0, 1, 3'd0, 2'b00));
      tbl.push_back(mk(0, 2'b11, 1, 2'b00, 0, 32'hA3, 0, 1, 3'd0, 2'b10));
      tbl.push_back(mk(0, 2'b11, 1, 2'b10, 1, 32'h20, 1, 0, 3'd1, 2'b10));
      tbl.push_back(mk(0, 2'b11, 1, 2'b10, 1, 32'h21, 0, 0, 3'd1, 2'b10));
      tbl.push_back(mk(0, 2'b11, 1, 2'b10, 1, 32'h22, 0, 0, 3'd1, 2'b10));
      tbl.push_back(mk(0, 2'b11, 1, 2'b10, 1, 32'h23, 0, 1, 3'd1, 2'b00));
      tbl.push_back(mk(0, 2'b11, 1, 2'b00, 0, 32'h23, 0, 1, 3'd1, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA4, 1, 0, 3'd0, 2'b01));
      // sink stalls three cycles mid-packet
      tbl.push_back(mk(1, 2'b00, 1, 2'b00, 0, 32'h00, 0, 0, 3'd0, 2'b00));
      tbl.push_back(mk(0, 2'b01, 1, 2'b00, 0, 32'h00, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 1, 2'b01, 1, 32'hA0, 1, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 1, 2'b01, 1, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 0, 2'b00, 1, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 0, 2'b00, 1, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 0, 2'b00, 1, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 1, 2'b01, 1, 32'hA2, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b01, 1, 2'b01, 1, 32'hA3, 0, 1, 3'd0, 2'b00));
      tbl.push_back(mk(0, 2'b00, 1, 2'b00, 0, 32'hA3, 0, 1, 3'd0, 2'b00));
      // granted requester drops valid mid-packet; requester 1 must wait
      tbl.push_back(mk(1, 2'b00, 1, 2'b00, 0, 32'h00, 0, 0, 3'd0, 2'b00));
      tbl.push_back(mk(0, 2'b11, 1, 2'b00, 0, 32'h00, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA0, 1, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b10, 1, 2'b01, 0, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b10, 1, 2'b01, 0, 32'hA1, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA2, 0, 0, 3'd0, 2'b01));
      tbl.push_back(mk(0, 2'b11, 1, 2'b01, 1, 32'hA3, 0, 1, 3'd0, 2'b00));
      tbl.push_back(mk(0, 2'b11, 1, 2'b00, 0, 32'hA3, 0, 1, 3'd0, 2'b10));
      tbl.push_back(mk(0, 2'b11, 1, 2'b10, 1, 32'h20, 1, 0, 3'd1, 2'b10));

      for (int i = 0; i < tbl.size(); i++) begin
         rst_a = tbl[i].rst;
         set_a(tbl[i].v, tbl[i].r);
         chk($sformatf("tbl%0d_req_ready", i), 64'(a_if.req_ready), 64'(tbl[i].rdy));
         tick_a();
         if (tbl[i].rst) pseq_a = '{0, 0};
         chk($sformatf("tbl%0d_src_valid", i), 64'(a_if.src_valid), 64'(tbl[i].sv));
         chk($sformatf("tbl%0d_src_data", i), 64'(a_if.src_data), 64'(tbl[i].d));
         chk($sformatf("tbl%0d_src_sop", i), 64'(a_if.src_sop), 64'(tbl[i].sop));
         chk($sformatf("tbl%0d_src_eop", i), 64'(a_if.src_eop), 64'(tbl[i].eop));
         chk($sformatf("tbl%0d_src_channel", i), 64'(a_if.src_channel), 64'(tbl[i].ch));
         chk($sformatf("tbl%0d_grant", i), 64'(a_if.grant), 64'(tbl[i].g));
         chk($sformatf("tbl%0d_busy", i), 64'(a_if.busy), 64'((|tbl[i].g) | tbl[i].sv));
      end
      rst_a = 1'b0;

      // Asynchronous reset after beat 2 of 4, checked before the next clock edge
      reset_a();
      set_a(2'b01, 1'b1); tick_a();
      set_a(2'b01, 1'b1); tick_a();
      set_a(2'b01, 1'b1); tick_a();
      chk("pre_rst_src_data", 64'(a_if.src_data), 64'h A1);
      rst_a = 1'b1;
      #1;
      chk("async_src_valid", 64'(a_if.src_valid), 64'd0);
      chk("async_src_data", 64'(a_if.src_data), 64'd0);
      chk("async_src_sop", 64'(a_if.src_sop), 64'd0);
      chk("async_src_eop", 64'(a_if.src_eop), 64'd0);
      chk("async_grant", 64'(a_if.grant), 64'd0);
      chk("async_busy", 64'(a_if.busy), 64'd0);
      chk("async_req_ready", 64'(a_if.req_ready), 64'd0);
      #1;
      rst_a = 1'b0;
      pseq_a = '{0, 0};
      set_a(2'b11, 1'b1); tick_a();
      chk("post_rst_grant", 64'(a_if.grant), 64'b01);
      set_a(2'b11, 1'b1); tick_a();
      chk("post_rst_src_data", 64'(a_if.src_data), 64'hA0);
      chk("post_rst_src_sop", 64'(a_if.src_sop), 64'd1);
      chk("post_rst_src_channel", 64'(a_if.src_channel), 64'd0);

      // Randomized traffic with random sink backpressure
      reset_a();
      m_xfer = 1'b0; m_ov = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_od = '0;
      m_owner = 0; m_last = 1; m_beat = 0; m_ch = 0; m_seq = '{0, 0};
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic [1:0] v;
         logic       r;
         v[0] = ($urandom_range(0, 3) != 0);
         v[1] = ($urandom_range(0, 3) != 0);
         r    = ($urandom_range(0, 3) != 0);
         set_a(v, r);
         m_free = !m_ov || r;
         chk("rnd_req_ready", 64'(a_if.req_ready),
             (m_xfer && m_free) ? (64'd1 << m_owner) : 64'd0);
         m_acc = m_xfer && m_free && v[m_owner];
         m_was = m_xfer;
         if (m_acc) begin
            m_od  = base_a[m_owner] + m_seq[m_owner];
            m_seq[m_owner]++;
            m_sop = (m_beat == 0);
            m_eop = (m_beat == PKT_A - 1);
            m_ch  = m_owner;
            m_ov  = 1'b1;
            m_beat++;
            if (m_beat == PKT_A) begin
               m_xfer = 1'b0;
               m_last = m_owner;
            end
         end else if (m_ov && r) begin
            m_ov = 1'b0;
         end
         if (!m_was && v != 2'b00) begin
            m_pick = 1'b0;
            for (int k = 1; k <= 2; k++) begin
               m_c = (m_last + k) % 2;
               if (!m_pick && v[m_c]) begin
                  m_pick  = 1'b1;
                  m_owner = m_c;
               end
            end
            m_xfer = 1'b1;
            m_beat = 0;
         end
         tick_a();
         chk("rnd_src_valid", 64'(a_if.src_valid), 64'(m_ov));
         chk("rnd_src_data", 64'(a_if.src_data), 64'(m_od));
         chk("rnd_src_sop", 64'(a_if.src_sop), 64'(m_sop));
         chk("rnd_src_eop", 64'(a_if.src_eop), 64'(m_eop));
         chk("rnd_src_channel", 64'(a_if.src_channel), 64'(m_ch));
         chk("rnd_grant", 64'(a_if.grant), m_xfer ? (64'd1 << m_owner) : 64'd0);
         chk("rnd_busy", 64'(a_if.busy), 64'(m_xfer | m_ov));
      end
      set_a(2'b00, 1'b1);

      // Single-beat packets across three requesters: channel order 0,1,2,0
      rst_b = 1'b0;
      set_b(3'b111, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick_b();
         chk($sformatf("b%0d_grant", k), 64'(b_if.grant), 64'd1 << (k % 3));
         chk($sformatf("b%0d_bubble_valid", k), 64'(b_if.src_valid), 64'd0);
         set_b(3'b111, 1'b1);
         tick_b();
         chk($sformatf("b%0d_src_valid", k), 64'(b_if.src_valid), 64'd1);
         chk($sformatf("b%0d_src_sop", k), 64'(b_if.src_sop), 64'd1);
         chk($sformatf("b%0d_src_eop", k), 64'(b_if.src_eop), 64'd1);
         chk($sformatf("b%0d_src_channel", k), 64'(b_if.src_channel), 64'(k % 3));
         chk($sformatf("b%0d_src_data", k), 64'(b_if.src_data), 64'(base_b[k % 3] + 32'(k / 3)));
         chk($sformatf("b%0d_grant_clear", k), 64'(b_if.grant), 64'd0);
         set_b(3'b111, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
